// File: rtl/gb_bus_pkg.sv
// Shared definitions for the Game Boy bus arbiter: owner encoding,
// arbiter FSM state encoding and default HRAM bounds.
package gb_bus_pkg;

  localparam logic [1:0] OWN_CPU  = 2'd0;
  localparam logic [1:0] OWN_OAM  = 2'd1;
  localparam logic [1:0] OWN_HDMA = 2'd2;

  // OAM ownership is combinational on oam_active, so the FSM only tracks
  // whether HDMA holds the bus.
  typedef enum logic {
    S_CPU  = 1'b0,
    S_HDMA = 1'b1
  } arb_state_e;

  localparam logic [15:0] HRAM_LO_DEF  = 16'hff80;
  localparam logic [15:0] HRAM_HI_DEF  = 16'hfffe;
  localparam logic [7:0]  OPEN_BUS_DEF = 8'hff;

endpackage

// File: rtl/bus_arbiter_addr_window.sv
// Combinational inclusive address-range compare (LO <= address <= HI).
// Used for the HRAM carve-out and reusable by the memory map decoder.
module addr_window #(
  parameter int unsigned      W  = 16,
  parameter logic [W-1:0]     LO = '0,
  parameter logic [W-1:0]     HI = '1
) (
  input  logic [W-1:0] address,
  output logic         hit
);

  assign hit = (address >= LO) && (address <= HI);

endmodule

// File: rtl/bus_arbiter.sv
// Game Boy system bus arbiter: CPU, OAM DMA and CGB HDMA share one bus.
// HRAM is on a private CPU port so the CPU keeps running from HRAM during
// OAM DMA. HDMA ownership stalls non-HRAM CPU accesses via cpu_wait.
// Optional build macro: ARB_BUS_CONFLICT_EN -- a CPU read blocked by OAM DMA
// returns the byte currently on the shared bus instead of open-bus 0xff.
//
// Handshake: a CPU access is an active cpu_load/cpu_store; while cpu_wait=1
// the CPU holds the same access and it completes in the first cycle with
// cpu_wait=0. HDMA holds hdma_req and presents its access; the access is
// taken in each cycle where hdma_ack=1, and HDMA advances only then.
module bus_arbiter
  import gb_bus_pkg::*;
#(
  parameter logic [15:0] HRAM_LO  = HRAM_LO_DEF,
  parameter logic [15:0] HRAM_HI  = HRAM_HI_DEF,
  parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEF
) (
  input  logic        clockgb,
  input  logic        reset,
  // CPU
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_outdata,
  output logic [7:0]  cpu_indata,
  input  logic        cpu_load,
  input  logic        cpu_store,
  output logic        cpu_wait,
  // OAM DMA
  input  logic [15:0] oam_address,
  input  logic [7:0]  oam_outdata,
  input  logic        oam_load,
  input  logic        oam_store,
  input  logic        oam_active,
  output logic [7:0]  oam_indata,
  // HDMA
  input  logic        hdma_req,
  input  logic [15:0] hdma_address,
  input  logic [7:0]  hdma_outdata,
  input  logic        hdma_load,
  input  logic        hdma_store,
  output logic [7:0]  hdma_indata,
  output logic        hdma_ack,
  // shared bus
  output logic [15:0] bus_address,
  output logic [7:0]  bus_outdata,
  output logic        bus_load,
  output logic        bus_store,
  input  logic [7:0]  bus_indata,
  // HRAM port
  output logic [6:0]  hram_address,
  output logic [7:0]  hram_outdata,
  output logic        hram_load,
  output logic        hram_store,
  input  logic [7:0]  hram_indata,
  output logic [1:0]  owner
);

  arb_state_e state, state_next;
  logic       cpu_in_hram;
  logic [7:0] cpu_rd_sel;

  addr_window #(.W(16), .LO(HRAM_LO), .HI(HRAM_HI)) u_hram_window (
    .address (cpu_address),
    .hit     (cpu_in_hram)
  );

  // State register: reset always returns the bus to the CPU.
  always_ff @(posedge clockgb) begin
    if (reset) state <= S_CPU;
    else       state <= state_next;
  end

  // Next state: OAM DMA freezes the HDMA/CPU decision while it runs.
  always_comb begin
    state_next = state;
    if (!oam_active) begin
      case (state)
        S_CPU:   if (hdma_req)  state_next = S_HDMA;
        S_HDMA:  if (!hdma_req) state_next = S_CPU;
        default: state_next = S_CPU;
      endcase
    end
  end

  assign hdma_ack = (state == S_HDMA) && !oam_active;
  assign cpu_wait = (state == S_HDMA) && (cpu_load || cpu_store) && !cpu_in_hram;

  // Owner selection and shared-bus mux; only the owner's strobes reach the bus.
  always_comb begin
    owner       = OWN_CPU;
    bus_address = cpu_address;
    bus_outdata = cpu_outdata;
    bus_load    = 1'b0;
    bus_store   = 1'b0;
    if (oam_active) begin
      owner       = OWN_OAM;
      bus_address = oam_address;
      bus_outdata = oam_outdata;
      bus_load    = oam_load;
      bus_store   = oam_store;
    end else if (state == S_HDMA) begin
      owner       = OWN_HDMA;
      bus_address = hdma_address;
      bus_outdata = hdma_outdata;
      bus_load    = hdma_load;
      bus_store   = hdma_store;
    end else begin
      bus_load    = cpu_load  && !cpu_in_hram;
      bus_store   = cpu_store && !cpu_in_hram;
    end
  end

  // HRAM is private to the CPU and independent of bus ownership.
  assign hram_address = cpu_address[6:0];
  assign hram_outdata = cpu_outdata;
  assign hram_load    = cpu_load  && cpu_in_hram;
  assign hram_store   = cpu_store && cpu_in_hram;

  assign oam_indata  = bus_indata;
  assign hdma_indata = bus_indata;

  // CPU read source: HRAM, the shared bus, or the blocked-read value.
  always_comb begin
    cpu_rd_sel = bus_indata;
    if (cpu_in_hram) begin
      cpu_rd_sel = hram_indata;
    end else if (oam_active) begin
`ifdef ARB_BUS_CONFLICT_EN
      cpu_rd_sel = bus_indata;
`else
      cpu_rd_sel = OPEN_BUS;
`endif
    end
  end

  // CPU read data register: loads when a CPU read completes, else holds.
  always_ff @(posedge clockgb) begin
    if (reset)                      cpu_indata <= OPEN_BUS;
    else if (cpu_load && !cpu_wait) cpu_indata <= cpu_rd_sel;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomised
// CPU loads, with a scoreboard queue for registered CPU read data.
module tb_bus_arbiter;

  logic        clockgb = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_outdata, cpu_indata;
  logic        cpu_load, cpu_store, cpu_wait;
  logic [15:0] oam_address;
  logic [7:0]  oam_outdata, oam_indata;
  logic        oam_load, oam_store, oam_active;
  logic        hdma_req;
  logic [15:0] hdma_address;
  logic [7:0]  hdma_outdata, hdma_indata;
  logic        hdma_load, hdma_store, hdma_ack;
  logic [15:0] bus_address;
  logic [7:0]  bus_outdata, bus_indata;
  logic        bus_load, bus_store;
  logic [6:0]  hram_address;
  logic [7:0]  hram_outdata, hram_indata;
  logic        hram_load, hram_store;
  logic [1:0]  owner;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic       cap_now  = 1'b0;
  logic [7:0] last_exp = 8'hff;

  bus_arbiter dut (
    .clockgb(clockgb), .reset(reset),
    .cpu_address(cpu_address), .cpu_outdata(cpu_outdata), .cpu_indata(cpu_indata),
    .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_wait(cpu_wait),
    .oam_address(oam_address), .oam_outdata(oam_outdata), .oam_load(oam_load),
    .oam_store(oam_store), .oam_active(oam_active), .oam_indata(oam_indata),
    .hdma_req(hdma_req), .hdma_address(hdma_address), .hdma_outdata(hdma_outdata),
    .hdma_load(hdma_load), .hdma_store(hdma_store), .hdma_indata(hdma_indata),
    .hdma_ack(hdma_ack),
    .bus_address(bus_address), .bus_outdata(bus_outdata), .bus_load(bus_load),
    .bus_store(bus_store), .bus_indata(bus_indata),
    .hram_address(hram_address), .hram_outdata(hram_outdata), .hram_load(hram_load),
    .hram_store(hram_store), .hram_indata(hram_indata),
    .owner(owner)
  );

  // clock / reset
  always #5 clockgb = ~clockgb;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    cpu_address = 16'h0000; cpu_outdata = 8'h00; cpu_load = 1'b0; cpu_store = 1'b0;
    oam_address = 16'h0000; oam_outdata = 8'h00; oam_load = 1'b0; oam_store = 1'b0;
    oam_active = 1'b0;
    hdma_req = 1'b0; hdma_address = 16'h0000; hdma_outdata = 8'h00;
    hdma_load = 1'b0; hdma_store = 1'b0;
    bus_indata = 8'h00; hram_indata = 8'h00;
  endtask

  // Declares that the CPU load driven this cycle completes with value e.
  task automatic expect_load(input logic [7:0] e);
    exp_q.push_back(e);
    cap_now = 1'b1;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    logic [7:0] e;
    @(posedge clockgb);
    #1;
    if (cap_now) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        chk("cpu_indata", {8'h00, cpu_indata}, {8'h00, e});
        last_exp = e;
      end
    end else begin
      chk("cpu_indata_hold", {8'h00, cpu_indata}, {8'h00, last_exp});
    end
    cap_now = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int          acks, waits;

    idle();
    reset = 1'b1;
    @(posedge clockgb); #1;
    @(posedge clockgb); #1;
    reset = 1'b0;

    // reset state
    chk("rst_owner",      {14'd0, owner}, 16'd0);
    chk("rst_bus_load",   {15'd0, bus_load}, 16'd0);
    chk("rst_bus_store",  {15'd0, bus_store}, 16'd0);
    chk("rst_hram_load",  {15'd0, hram_load}, 16'd0);
    chk("rst_hram_store", {15'd0, hram_store}, 16'd0);
    chk("rst_hdma_ack",   {15'd0, hdma_ack}, 16'd0);
    chk("rst_cpu_wait",   {15'd0, cpu_wait}, 16'd0);
    chk("rst_cpu_indata", {8'h00, cpu_indata}, 16'h00ff);

    // plain CPU load from work RAM
    cpu_address = 16'hc000; cpu_load = 1'b1; bus_indata = 8'h5a;
    #1;
    chk("t1_bus_load", {15'd0, bus_load}, 16'd1);
    chk("t1_bus_addr", bus_address, 16'hc000);
    chk("t1_owner",    {14'd0, owner}, 16'd0);
    chk("t1_hram_load", {15'd0, hram_load}, 16'd0);
    expect_load(8'h5a);
    tick();

    // randomised CPU loads: work RAM via the bus, HRAM via the private port
    for (int i = 0; i < 8; i++) begin
      idle();
      d = 8'($urandom_range(0, 255));
      if (i % 2 == 0) begin
        a = 16'($urandom_range(16'hc000, 16'hdfff));
        cpu_address = a; cpu_load = 1'b1; bus_indata = d; hram_indata = ~d;
        #1;
        chk("rnd_bus_load", {15'd0, bus_load}, 16'd1);
        chk("rnd_bus_addr", bus_address, a);
      end else begin
        a = 16'($urandom_range(16'hff80, 16'hfffe));
        cpu_address = a; cpu_load = 1'b1; hram_indata = d; bus_indata = ~d;
        #1;
        chk("rnd_hram_load", {15'd0, hram_load}, 16'd1);
        chk("rnd_hram_bus_load", {15'd0, bus_load}, 16'd0);
        chk("rnd_hram_addr", {9'd0, hram_address}, {9'd0, a[6:0]});
      end
      expect_load(d);
      tick();
    end

    // IE register (0xffff) sits just above HRAM and goes to the bus
    idle();
    cpu_address = 16'hffff; cpu_load = 1'b1; bus_indata = 8'h1f; hram_indata = 8'he0;
    #1;
    chk("ie_bus_load",  {15'd0, bus_load}, 16'd1);
    chk("ie_hram_load", {15'd0, hram_load}, 16'd0);
    expect_load(8'h1f);
    tick();

    // OAM DMA owns the bus: CPU store dropped, CPU load blocked
    idle();
    oam_active = 1'b1; oam_load = 1'b1; oam_address = 16'hc100;
    cpu_address = 16'hc000; cpu_store = 1'b1; cpu_outdata = 8'h11;
    #1;
    chk("t2_owner",     {14'd0, owner}, 16'd1);
    chk("t2_bus_addr",  bus_address, 16'hc100);
    chk("t2_bus_load",  {15'd0, bus_load}, 16'd1);
    chk("t2_bus_store", {15'd0, bus_store}, 16'd0);
    chk("t2_cpu_wait",  {15'd0, cpu_wait}, 16'd0);
    tick();
    cpu_store = 1'b0; cpu_load = 1'b1; bus_indata = 8'h77;
    #1;
    chk("t2_oam_indata", {8'h00, oam_indata}, 16'h0077);
`ifdef ARB_BUS_CONFLICT_EN
    expect_load(8'h77);
`else
    expect_load(8'hff);
`endif
    tick();

    // OAM DMA active; CPU store into HRAM proceeds on the private port
    cpu_load = 1'b0; cpu_address = 16'hff90; cpu_store = 1'b1; cpu_outdata = 8'h3c;
    #1;
    chk("t3_hram_store", {15'd0, hram_store}, 16'd1);
    chk("t3_hram_addr",  {9'd0, hram_address}, 16'h0010);
    chk("t3_hram_data",  {8'h00, hram_outdata}, 16'h003c);
    chk("t3_bus_store",  {15'd0, bus_store}, 16'd0);
    chk("t3_bus_addr",   bus_address, 16'hc100);
    tick();

    // HDMA: req held 4 cycles, CPU load stalled at 0x8000
    idle();
    tick();
    hdma_req = 1'b1; hdma_load = 1'b1; hdma_address = 16'h9000;
    #1;
    chk("t4_pre_owner", {14'd0, owner}, 16'd0);
    chk("t4_pre_ack",   {15'd0, hdma_ack}, 16'd0);
    tick();
    acks = 0; waits = 0;
    for (int i = 0; i < 4; i++) begin
      hdma_req = (i < 3);
      hdma_address = 16'h9000 + 16'(i + 1);
      cpu_address = 16'h8000; cpu_load = 1'b1;
      bus_indata = 8'(8'h20 + i);
      #1;
      chk("t4_owner",    {14'd0, owner}, 16'd2);
      chk("t4_bus_addr", bus_address, 16'h9000 + 16'(i + 1));
      chk("t4_hdma_in",  {8'h00, hdma_indata}, {8'h00, 8'(8'h20 + i)});
      if (hdma_ack) acks++;
      if (cpu_wait) waits++;
      tick();
    end
    chk("t4_ack_count",  16'(acks), 16'd4);
    chk("t4_wait_count", 16'(waits), 16'd4);
    bus_indata = 8'h42; hdma_load = 1'b0;
    #1;
    chk("t4_post_owner", {14'd0, owner}, 16'd0);
    chk("t4_post_wait",  {15'd0, cpu_wait}, 16'd0);
    chk("t4_post_addr",  bus_address, 16'h8000);
    chk("t4_post_ack",   {15'd0, hdma_ack}, 16'd0);
    expect_load(8'h42);
    tick();

    // OAM DMA interrupts HDMA in its 2nd cycle for 3 cycles
    idle();
    hdma_req = 1'b1; hdma_load = 1'b1; hdma_address = 16'h9800;
    tick();
    cpu_address = 16'h8000; cpu_load = 1'b1;
    #1;
    chk("t5_first_ack", {15'd0, hdma_ack}, 16'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      oam_active = 1'b1; oam_load = 1'b1; oam_address = 16'hc000 + 16'(i);
      #1;
      chk("t5_oam_owner", {14'd0, owner}, 16'd1);
      chk("t5_oam_ack",   {15'd0, hdma_ack}, 16'd0);
      chk("t5_oam_wait",  {15'd0, cpu_wait}, 16'd1);
      chk("t5_oam_addr",  bus_address, 16'hc000 + 16'(i));
      tick();
    end
    oam_active = 1'b0; oam_load = 1'b0; hdma_req = 1'b0;
    #1;
    chk("t5_resume_owner", {14'd0, owner}, 16'd2);
    chk("t5_resume_ack",   {15'd0, hdma_ack}, 16'd1);
    tick();
    hdma_load = 1'b0; bus_indata = 8'h99;
    #1;
    chk("t5_end_owner", {14'd0, owner}, 16'd0);
    expect_load(8'h99);
    tick();

    // reset while HDMA owns the bus
    idle();
    hdma_req = 1'b1; hdma_load = 1'b1;
    tick();
    chk("t6_pre_owner", {14'd0, owner}, 16'd2);
    reset = 1'b1;
    @(posedge clockgb); #1;
    reset = 1'b0;
    last_exp = 8'hff;
    chk("t6_owner",  {14'd0, owner}, 16'd0);
    chk("t6_ack",    {15'd0, hdma_ack}, 16'd0);
    chk("t6_indata", {8'h00, cpu_indata}, 16'h00ff);
    oam_active = 1'b1;
    #1;
    chk("t6_oam_owner", {14'd0, owner}, 16'd1);
    idle();
    tick();

    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
